wb_regfile: RTL
===============

Name: wb_regfile

Overview:
Writeback-end consumer of the MEM/WB pipeline interface. It selects the writeback data (memory vs ALU) and commits it into a 32x32 general-purpose register file. It serves two combinational read ports to the ID stage and exposes the committed write for EX-stage forwarding. It sits at the tail of the 5-stage MIPS pipeline, directly after the MEM/WB register.

Parameters:
- DATA_W, 32, register and data width
- NREG, 32, number of architectural registers; index width ADDR_W = clog2(NREG) = 5
- CNT_W, 32, width of the retired-write counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_WB_ctrl_Mem2Reg  in  1  1 = write MemData, 0 = write ALUData
- i_WB_ctrl_RegWrite  in  1  writeback enable
- i_WB_data_RegAddrW  in  32  destination register; bits [4:0] used, [31:5] ignored
- i_WB_data_MemData  in  32  load data from MEM/WB
- i_WB_data_ALUData  in  32  ALU result from MEM/WB
- i_ID_RegAddrA  in  5  read port A index
- i_ID_RegAddrB  in  5  read port B index
- o_ID_RegDataA  out  32  read port A data
- o_ID_RegDataB  out  32  read port B data
- o_FWD_valid  out  1  writeback committed last cycle
- o_FWD_addr  out  5  destination of that writeback
- o_FWD_data  out  32  data of that writeback
- o_WB_count  out  CNT_W  number of committed (non-$0) writes since reset

Behaviour:
- Write data: wdata = Mem2Reg ? MemData : ALUData (combinational).
- Commit condition: we = RegWrite && (RegAddrW[4:0] != 0). On a rising edge with we=1, regs[addr] <= wdata.
- $0 is hardwired: reads of index 0 return 0; writes to 0 are dropped and do not count.
- Read ports are combinational from storage. Same-cycle write/read of the same nonzero index behaves as defined under Optional Feature.
- Ports A and B may address the same register; both return identical data.
- FWD register, 1-cycle latency:
  - o_FWD_valid <= we
  - o_FWD_addr <= we ? addr : 0
  - o_FWD_data <= we ? wdata : 0
  - Holds 0/0/0 when no commit occurs.
- Counter: o_WB_count increments by 1 per committed write and wraps modulo 2^CNT_W (all-ones + 1 -> 0).
- Reset (rst=1 at an edge):
  - All 32 registers, the FWD outputs and the counter go to 0.
  - Reset has priority over a simultaneous write, so that write is lost.
  - Reset asserted mid-stream clears state at that edge; writes resume on the first edge with rst=0.
- RegWrite=0: storage, counter and FWD_valid are unaffected by Mem2Reg/addr/data values, including X on the data inputs.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: internal write-through. If we=1 and the read index equals the write index (nonzero), the read port returns wdata in the same cycle. This removes the ID/WB hazard.
- Undefined: read ports return the stored (old) value in the write cycle. The new value is visible from the following cycle, and the hazard unit must stall one cycle.
- Port list and FWD/counter behaviour are identical in both builds.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W, REG_ADDR_W=5, NREG and REG_ZERO=5'd0 constants.
  - Typedef reg_addr_t (5-bit) and word_t (32-bit), reused by the ID, hazard and forwarding units.
- One natural sub-module: regfile_2r1w, the raw 2-read/1-write storage with $0 masking and reset clear.
- wb_regfile wraps regfile_2r1w with the data mux, bypass, FWD register and counter.

Test Plan:
- Reset, then read all 32 indices on A and B -> all 0; FWD_valid=0; o_WB_count=0.
- Mem2Reg=0, RegWrite=1, addr=5, ALU=0x1234_5678, Mem=0xDEAD_BEEF -> next cycle reg5 reads 0x1234_5678; FWD_valid=1, addr=5, data=0x1234_5678; count=1. Repeat with Mem2Reg=1 on addr 6 -> reg6=0xDEAD_BEEF; count=2.
- RegWrite=1, addr=0, ALU=0xFFFF_FFFF -> reg0 still reads 0; FWD_valid=0; count unchanged. Repeat with addr=0x0000_0025 (upper bits set) -> writes reg5.
- Same-cycle write reg7=0xA5A5_A5A5 (old 0x1) while A=B=7 -> with BYPASS_EN both ports read 0xA5A5_A5A5 that cycle; without it both read 0x1, then 0xA5A5_A5A5 next cycle.
- Preload count to 0xFFFF_FFFF via forced state or a long run, then one commit -> count=0.
- Assert rst together with RegWrite=1, addr=9, data=0x55 -> reg9=0, count=0, FWD_valid=0 after the edge; an identical write after rst deasserts -> reg9=0x55.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types, reused by the ID, hazard,
// forwarding and writeback units.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when the index names a real (writable) register rather than $0.
    function automatic logic is_writable(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage : mips_pkg

// File: rtl/regfile_2r1w.sv
// Raw 2-read/1-write register storage. $0 reads as zero and ignores writes;
// reset clears every register. Reads are combinational from storage.
module regfile_2r1w
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t raddr_a,
    input  reg_addr_t raddr_b,
    output word_t     rdata_a,
    output word_t     rdata_b
);

    word_t regs_reg [NREG];

    // One storage word per register; $0 has no write path and stays at zero.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_reg[gi] <= '0;
                end else if ((gi != 0) && we && (waddr == reg_addr_t'(gi))) begin
                    regs_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Combinational read with $0 masking on both ports.
    always_comb begin
        rdata_a = is_writable(raddr_a) ? regs_reg[raddr_a] : '0;
        rdata_b = is_writable(raddr_b) ? regs_reg[raddr_b] : '0;
    end

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Writeback stage: selects memory or ALU data, commits it into the register
// file, serves two read ports to ID and registers the committed write for
// EX-stage forwarding. Also counts committed (non-$0) writes.
// Build option: define WB_REGFILE_BYPASS_EN to make the read ports return the
// value being written in the same cycle (write-through); otherwise the old
// value is returned during the write cycle.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_WB_ctrl_Mem2Reg,
    input  logic              i_WB_ctrl_RegWrite,
    input  logic [31:0]       i_WB_data_RegAddrW,
    input  logic [DATA_W-1:0] i_WB_data_MemData,
    input  logic [DATA_W-1:0] i_WB_data_ALUData,
    input  logic [4:0]        i_ID_RegAddrA,
    input  logic [4:0]        i_ID_RegAddrB,
    output logic [DATA_W-1:0] o_ID_RegDataA,
    output logic [DATA_W-1:0] o_ID_RegDataB,
    output logic              o_FWD_valid,
    output logic [4:0]        o_FWD_addr,
    output logic [DATA_W-1:0] o_FWD_data,
    output logic [CNT_W-1:0]  o_WB_count
);

    localparam int ADDR_W = $clog2(NREG);

    reg_addr_t addr;
    word_t     wdata;
    logic      we;
    word_t     stored_a;
    word_t     stored_b;

    // Only the low index bits select a register; the rest of the field is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_WB_data_RegAddrW[31:ADDR_W];

    // Writeback data select and commit qualification ($0 never commits).
    always_comb begin
        addr  = i_WB_data_RegAddrW[ADDR_W-1:0];
        wdata = i_WB_ctrl_Mem2Reg ? i_WB_data_MemData : i_WB_data_ALUData;
        we    = i_WB_ctrl_RegWrite && is_writable(addr);
    end

    regfile_2r1w u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (addr),
        .wdata   (wdata),
        .raddr_a (i_ID_RegAddrA),
        .raddr_b (i_ID_RegAddrB),
        .rdata_a (stored_a),
        .rdata_b (stored_b)
    );

`ifdef WB_REGFILE_BYPASS_EN
    // Write-through: a read of the register being written sees the new value now.
    always_comb begin
        o_ID_RegDataA = (we && (i_ID_RegAddrA == addr)) ? wdata : stored_a;
        o_ID_RegDataB = (we && (i_ID_RegAddrB == addr)) ? wdata : stored_b;
    end
`else
    // No write-through: the new value appears on the cycle after the write.
    always_comb begin
        o_ID_RegDataA = stored_a;
        o_ID_RegDataB = stored_b;
    end
`endif

    logic              fwd_valid_reg;
    reg_addr_t         fwd_addr_reg;
    word_t             fwd_data_reg;
    logic [CNT_W-1:0]  count_reg;

    // Forwarding register: mirrors last cycle's commit, zeroed when nothing committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_reg <= 1'b0;
            fwd_addr_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            fwd_valid_reg <= we;
            fwd_addr_reg  <= we ? addr  : '0;
            fwd_data_reg  <= we ? wdata : '0;
        end
    end

    // Retired-write counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (we) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign o_FWD_valid = fwd_valid_reg;
    assign o_FWD_addr  = fwd_addr_reg;
    assign o_FWD_data  = fwd_data_reg;
    assign o_WB_count  = count_reg;

endmodule : wb_regfile
